muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit sitting between the register file read ports and the write-back mux. It accepts rs1/rs2 operands plus funct3 and the destination register index, computes over multiple cycles, and returns a one-cycle `done` pulse with the result and the destination index so write-back can drive the register file write enable. The core stalls on `busy`.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (MULDIV_DIV_EN enables divide ops)
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN + 1);
`ifdef MULDIV_DIV_EN
  localparam int OPW = 3;
`else
  localparam int OPW = 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [OPW-1:0]      r_op;
  logic [4:0]          r_rd;
  logic [4:0]          r_rd_out;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_step, w_step;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_mul_res, w_fix;

  assign w_a_signed = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
  assign w_b_signed = w_a_signed && (funct3 != 3'd2);
  assign w_sa       = w_a_signed & rs1_data[XLEN-1];
  assign w_sb       = w_b_signed & rs2_data[XLEN-1];
  assign w_mag_a    = w_sa ? -rs1_data : rs1_data;
  assign w_mag_b    = w_sb ? -rs2_data : rs2_data;

  // Radix-2 shift-add: low half holds the remaining multiplier bits.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_prod     = r_neg ? -r_acc : r_acc;
  assign w_mul_res  = (r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
  logic                r_sa;
  logic                w_div0, w_ovf;
  logic [XLEN:0]       w_div_top, w_div_sub;
  logic                w_div_ge;
  logic [2*XLEN-1:0]   w_div_step;
  logic [XLEN-1:0]     w_quo, w_rem;

  assign w_div0        = funct3[2] && (rs2_data == '0);
  assign w_ovf         = funct3[2] && !funct3[0] && (rs2_data == '1) &&
                         (rs1_data == {1'b1, {(XLEN-1){1'b0}}});
  assign w_special     = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : rs1_data);

  // Restoring division: upper half is the partial remainder, lower half dividend/quotient.
  assign w_div_top  = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_sub  = w_div_top - {1'b0, r_b};
  assign w_div_ge   = w_div_top >= {1'b0, r_b};
  assign w_div_step = {w_div_ge ? w_div_sub[XLEN-1:0] : w_div_top[XLEN-1:0],
                       r_acc[XLEN-2:0], w_div_ge};
  assign w_step     = r_op[2] ? w_div_step : w_mul_step;

  assign w_quo = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fix = r_op[2] ? (r_op[1] ? w_rem : w_quo) : w_mul_res;
  assign illegal = 1'b0;
`else
  logic r_illegal;

  assign w_special     = funct3[2];
  assign w_special_res = '0;
  assign w_step        = w_mul_step;
  assign w_fix         = w_mul_res;
  assign illegal       = r_illegal && (r_state == S_DONE);
`endif

  assign w_accept = (r_state == S_IDLE) && start && !abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (abort)                    w_next = S_IDLE;
        else if (r_cnt == CW'(1))     w_next = S_FIX;
      end
      S_FIX:  w_next = abort ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
`ifdef MULDIV_DIV_EN
      r_sa     <= 1'b0;
`else
      r_illegal <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op  <= funct3[OPW-1:0];
      r_rd  <= rd_addr_in;
      r_b   <= w_mag_b;
      r_acc <= {{XLEN{1'b0}}, w_mag_a};
      r_neg <= w_sa ^ w_sb;
      r_cnt <= w_special ? '0 : CW'(XLEN);
`ifdef MULDIV_DIV_EN
      r_sa  <= w_sa;
`else
      r_illegal <= w_special;
`endif
      if (w_special) begin
        r_result <= w_special_res;
        r_rd_out <= rd_addr_in;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - CW'(1);
      r_acc <= w_step;
    end else if ((r_state == S_FIX) && !abort) begin
      r_result <= w_fix;
      r_rd_out <= r_rd;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign rd_addr_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (honours MULDIV_DIV_EN)
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        res_n, start, abort;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr_in;
  logic        busy, done, illegal;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .res_n(res_n), .start(start), .abort(abort), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
    .busy(busy), .done(done), .result(result), .rd_addr_out(rd_addr_out),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // dist_cyc > 0 injects an extra start request in that cycle of the operation.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_cyc, input logic exp_ill, input int dist_cyc);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (cyc == dist_cyc) begin
        funct3 = 3'd3; rs1_data = 32'd2; rs2_data = 32'd2; rd_addr_in = 5'd9; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (busy) busy_cnt++;
    check_eq({tag, ".done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc));
    check_eq({tag, ".result"}, result, exp);
    check_eq({tag, ".rd"}, 32'(rd_addr_out), 32'(rd));
    check_eq({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, ".idle"}, 32'(busy), 32'd0);
    last_res = exp;
    last_rd  = rd;
  endtask

  initial begin
    int cyc;
    int done_cnt;
    res_n = 1'b0; start = 1'b0; abort = 1'b0; funct3 = 3'd0;
    rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.illegal", 32'(illegal), 32'd0);
    check_eq("rst.result", result, 32'd0);
    check_eq("rst.rd", 32'(rd_addr_out), 32'd0);
    res_n = 1'b1;

    do_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 34, 1'b0, 0);
    do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 34, 1'b0, 0);
    do_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 34, 1'b0, 0);
    do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 34, 1'b0, 0);
`ifdef MULDIV_DIV_EN
    do_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 34, 1'b0, 0);
    do_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 34, 1'b0, 0);
    do_op("divu",    3'd5, 32'd100,      32'd7,        5'd8,  32'd14,       34, 1'b0, 0);
    do_op("remu",    3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        34, 1'b0, 0);
    do_op("divu0",   3'd5, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1,  1'b0, 0);
    do_op("rem0",    3'd6, 32'd5,        32'd0,        5'd12, 32'd5,        1,  1'b0, 0);
    do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1,  1'b0, 0);
    do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1,  1'b0, 0);
`else
    do_op("div_ill", 3'd4, 32'd10, 32'd2, 5'd6, 32'd0,  1,  1'b1, 0);
    do_op("mul_3x4", 3'd0, 32'd3,  32'd4, 5'd7, 32'd12, 34, 1'b0, 0);
`endif

    do_op("mul_busy_start", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 34, 1'b0, 5);

    do_op("mul_pre_abort", 3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 34, 1'b0, 0);
    @(negedge clk);
    funct3 = 3'd3; rs1_data = '1; rs2_data = '1; rd_addr_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort.busy", 32'(busy), 32'd0);
    done_cnt = 0;
    repeat (40) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check_eq("abort.no_done", 32'(done_cnt), 32'd0);
    check_eq("abort.result", result, last_res);
    check_eq("abort.rd", 32'(rd_addr_out), 32'(last_rd));

    funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start.busy", 32'(busy), 32'd0);

    funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFFFFFD; rd_addr_in = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("pre_reset.busy", 32'(busy), 32'd1);
    res_n = 1'b0;
    #1;
    check_eq("mid_reset.busy", 32'(busy), 32'd0);
    check_eq("mid_reset.done", 32'(done), 32'd0);
    check_eq("mid_reset.result", result, 32'd0);
    check_eq("mid_reset.rd", 32'(rd_addr_out), 32'd0);
    check_eq("mid_reset.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    res_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check_eq("post_reset.quiet", 32'(done_cnt), 32'd0);

    do_op("mul_after_reset", 3'd0, 32'd3, 32'd4, 5'd20, 32'd12, 34, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
